// File: rtl/ram_access_arbiter_if.sv
// ram_access_arbiter_if
// ---------------------
// Bundles the two requester handshakes and the RAM-side bus so that they can
// be passed around as a single port.
//
// Requester side (per port n = 1, 2):
//   reqn, wen, addrn, wdatan : request, write enable, address, write data
//   gntn                     : registered grant back to the requester
//   rdatan, rvalidn          : read data and its valid strobe
// RAM side:
//   ram_CE, ram_WE           : chip enable / write enable
//   ram_address              : RAM address
//   ram_data_output          : write data to the RAM
//   ram_data_input           : RAM read data, one cycle after a read
// Status:
//   busy                     : arbiter currently owned by a port
//
// Modports:
//   slave  : the arbiter itself
//   master : the environment (requesters plus RAM)
interface ram_access_arbiter_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 17
);
    logic                     req1;
    logic                     req2;
    logic                     we1;
    logic                     we2;
    logic [ADDRESS_WIDTH-1:0] addr1;
    logic [ADDRESS_WIDTH-1:0] addr2;
    logic [DATA_WIDTH-1:0]    wdata1;
    logic [DATA_WIDTH-1:0]    wdata2;
    logic                     gnt1;
    logic                     gnt2;
    logic [DATA_WIDTH-1:0]    rdata1;
    logic [DATA_WIDTH-1:0]    rdata2;
    logic                     rvalid1;
    logic                     rvalid2;
    logic                     ram_CE;
    logic                     ram_WE;
    logic [ADDRESS_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0]    ram_data_output;
    logic [DATA_WIDTH-1:0]    ram_data_input;
    logic                     busy;

    modport slave (
        input  req1, req2, we1, we2, addr1, addr2, wdata1, wdata2,
        input  ram_data_input,
        output gnt1, gnt2, rdata1, rdata2, rvalid1, rvalid2,
        output ram_CE, ram_WE, ram_address, ram_data_output, busy
    );

    modport master (
        output req1, req2, we1, we2, addr1, addr2, wdata1, wdata2,
        output ram_data_input,
        input  gnt1, gnt2, rdata1, rdata2, rvalid1, rvalid2,
        input  ram_CE, ram_WE, ram_address, ram_data_output, busy
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// ------------------
// Time-multiplexes one single-port synchronous RAM between the decoder
// (port 1) and the filter (port 2). Grants are registered, ties are broken
// round-robin, and an owner is forced to yield after MAX_BURST consecutive
// accesses while the other port is waiting. Read data is returned with a
// per-port valid strobe one cycle after the read access.
//
// Ports:
//   clk    : system clock, rising edge
//   rst    : asynchronous, active-high reset
//   io_bus : requester handshakes and RAM bus (ram_access_arbiter_if.slave)
module ram_access_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 17,
    parameter int MAX_BURST     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    ram_access_arbiter_if.slave    io_bus
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    localparam logic PORT1 = 1'b0;
    localparam logic PORT2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        OWN1,
        OWN2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_burstCnt;
    logic [CNT_W-1:0] w_nextBurstCnt;
    logic [CNT_W-1:0] w_burstCntInc;
    logic             r_lastServed;
    logic             w_nextLastServed;
    logic             r_rvalid1;
    logic             r_rvalid2;

    logic             w_access1;
    logic             w_access2;
    logic             w_ownerReq;
    logic             w_otherReq;
    state_t           w_otherState;
    logic             w_ownerPort;

    // An access is a granted cycle in which the owner is still requesting.
    assign w_access1 = io_bus.req1 && (r_state == OWN1);
    assign w_access2 = io_bus.req2 && (r_state == OWN2);

    // Owner/other view of the two ports, so OWN1 and OWN2 share one branch.
    assign w_ownerReq    = (r_state == OWN1) ? io_bus.req1 : io_bus.req2;
    assign w_otherReq    = (r_state == OWN1) ? io_bus.req2 : io_bus.req1;
    assign w_otherState  = (r_state == OWN1) ? OWN2 : OWN1;
    assign w_ownerPort   = (r_state == OWN1) ? PORT1 : PORT2;
    assign w_burstCntInc = r_burstCnt + CNT_W'(1);

    // State, burst counter, round-robin memory and read-valid pipeline.
    // Reset clears everything at once, dropping any in-flight read valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_burstCnt   <= '0;
            r_lastServed <= PORT2;
            r_rvalid1    <= 1'b0;
            r_rvalid2    <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_burstCnt   <= w_nextBurstCnt;
            r_lastServed <= w_nextLastServed;
            r_rvalid1    <= w_access1 && !io_bus.we1;
            r_rvalid2    <= w_access2 && !io_bus.we2;
        end
    end

    // Next-state logic. Release (owner drops req) takes priority over the
    // burst limit; a release cycle has no access, so the counter never
    // reaches the limit on that cycle anyway. When the limit is reached with
    // nobody waiting the counter simply restarts and ownership continues.
    always_comb begin
        w_nextState      = r_state;
        w_nextBurstCnt   = r_burstCnt;
        w_nextLastServed = r_lastServed;
        case (r_state)
            IDLE: begin
                w_nextBurstCnt = '0;
                if (io_bus.req1 && io_bus.req2) begin
                    w_nextState = (r_lastServed == PORT2) ? OWN1 : OWN2;
                end else if (io_bus.req1) begin
                    w_nextState = OWN1;
                end else if (io_bus.req2) begin
                    w_nextState = OWN2;
                end
            end
            OWN1, OWN2: begin
                if (!w_ownerReq) begin
                    w_nextState      = w_otherReq ? w_otherState : IDLE;
                    w_nextBurstCnt   = '0;
                    w_nextLastServed = w_ownerPort;
                end else if (w_burstCntInc == BURST_LIMIT) begin
                    w_nextBurstCnt = '0;
                    if (w_otherReq) begin
                        w_nextState      = w_otherState;
                        w_nextLastServed = w_ownerPort;
                    end
                end else begin
                    w_nextBurstCnt = w_burstCntInc;
                end
            end
            default: begin
                w_nextState    = IDLE;
                w_nextBurstCnt = '0;
            end
        endcase
    end

    // RAM drive is gated by the access, so reset forces it to zero directly.
    assign io_bus.ram_CE          = w_access1 || w_access2;
    assign io_bus.ram_WE          = (w_access1 && io_bus.we1) || (w_access2 && io_bus.we2);
    assign io_bus.ram_address     = w_access1 ? io_bus.addr1  :
                                    w_access2 ? io_bus.addr2  : '0;
    assign io_bus.ram_data_output = w_access1 ? io_bus.wdata1 :
                                    w_access2 ? io_bus.wdata2 : '0;

    assign io_bus.gnt1    = (r_state == OWN1);
    assign io_bus.gnt2    = (r_state == OWN2);
    assign io_bus.busy    = (r_state != IDLE);
    assign io_bus.rvalid1 = r_rvalid1;
    assign io_bus.rvalid2 = r_rvalid2;
    assign io_bus.rdata1  = r_rvalid1 ? io_bus.ram_data_input : '0;
    assign io_bus.rdata2  = r_rvalid2 ? io_bus.ram_data_input : '0;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter
// ---------------------
// Directed bench for ram_access_arbiter with MAX_BURST = 4. A per-cycle
// vector table covers ties, single reads, write-then-read, burst alternation
// and a waiting request that rises exactly on the burst limit; hand-written
// sequences cover a long uncontended burst and reset in the middle of a read.
// A small synchronous RAM model sits behind the arbiter; its initial contents
// follow memInit(), so read data is predictable.
module tb_ram_access_arbiter;

    localparam int DW = 8;
    localparam int AW = 17;
    localparam int MB = 4;

    logic clk;
    logic rst;

    ram_access_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    ram_access_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .MAX_BURST     (MB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int memInit(input int a);
        return (a * 7 + 3) & 255;
    endfunction

    // Synchronous single-port RAM model, loaded on its first clock edge.
    logic [DW-1:0] mem [0:255];
    bit            memLoaded;

    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= DW'(memInit(i));
            memLoaded <= 1'b1;
        end else if (bus.ram_CE) begin
            if (bus.ram_WE) mem[bus.ram_address[7:0]] <= bus.ram_data_output;
            else            bus.ram_data_input <= mem[bus.ram_address[7:0]];
        end
    end

    typedef struct {
        logic          r1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          r2, w2;
        logic [AW-1:0] a2;
        logic [DW-1:0] d2;
        logic          g1, g2, v1;
        logic [DW-1:0] rd1;
        logic          v2;
        logic [DW-1:0] rd2;
        logic          ce, we;
        logic [AW-1:0] ra;
        logic [DW-1:0] wd;
        logic          bsy;
    } vec_t;

    vec_t vecs[$];
    int   vectorsApplied;
    int   miscompares;

    function automatic vec_t mkVec(
        input int r1, w1, a1, d1, r2, w2, a2, d2,
        input int g1, g2, v1, rd1, v2, rd2, ce, we, ra, wd, bsy);
        vec_t v;
        v.r1 = r1[0];  v.w1 = w1[0];  v.a1 = a1[AW-1:0];  v.d1 = d1[DW-1:0];
        v.r2 = r2[0];  v.w2 = w2[0];  v.a2 = a2[AW-1:0];  v.d2 = d2[DW-1:0];
        v.g1 = g1[0];  v.g2 = g2[0];  v.v1 = v1[0];  v.rd1 = rd1[DW-1:0];
        v.v2 = v2[0];  v.rd2 = rd2[DW-1:0];
        v.ce = ce[0];  v.we = we[0];  v.ra = ra[AW-1:0];  v.wd = wd[DW-1:0];
        v.bsy = bsy[0];
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectorsApplied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.req1   = v.r1;  bus.we1 = v.w1;  bus.addr1 = v.a1;  bus.wdata1 = v.d1;
        bus.req2   = v.r2;  bus.we2 = v.w2;  bus.addr2 = v.a2;  bus.wdata2 = v.d2;
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        checkOutput($sformatf("v%0d gnt1", idx),    32'(bus.gnt1),            32'(v.g1));
        checkOutput($sformatf("v%0d gnt2", idx),    32'(bus.gnt2),            32'(v.g2));
        checkOutput($sformatf("v%0d rvalid1", idx), 32'(bus.rvalid1),         32'(v.v1));
        checkOutput($sformatf("v%0d rdata1", idx),  32'(bus.rdata1),          32'(v.rd1));
        checkOutput($sformatf("v%0d rvalid2", idx), 32'(bus.rvalid2),         32'(v.v2));
        checkOutput($sformatf("v%0d rdata2", idx),  32'(bus.rdata2),          32'(v.rd2));
        checkOutput($sformatf("v%0d ram_CE", idx),  32'(bus.ram_CE),          32'(v.ce));
        checkOutput($sformatf("v%0d ram_WE", idx),  32'(bus.ram_WE),          32'(v.we));
        checkOutput($sformatf("v%0d ram_addr", idx), 32'(bus.ram_address),   32'(v.ra));
        checkOutput($sformatf("v%0d ram_wdata", idx), 32'(bus.ram_data_output), 32'(v.wd));
        checkOutput($sformatf("v%0d busy", idx),    32'(bus.busy),            32'(v.bsy));
    endtask

    task automatic driveIdle();
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        bus.req2 = 1'b0; bus.we2 = 1'b0; bus.addr2 = '0; bus.wdata2 = '0;
    endtask

    task automatic buildTable();
        // Tie straight after reset: port 1 first, then a gapless handover.
        vecs.push_back(mkVec(1,0,10,0, 1,0,20,0,  0,0, 0,0, 0,0, 0,0,0,0, 0));
        vecs.push_back(mkVec(1,0,10,0, 1,0,20,0,  1,0, 0,0, 0,0, 1,0,10,0, 1));
        vecs.push_back(mkVec(1,0,11,0, 1,0,20,0,  1,0, 1,memInit(10), 0,0, 1,0,11,0, 1));
        vecs.push_back(mkVec(0,0,0,0,  1,0,20,0,  1,0, 1,memInit(11), 0,0, 0,0,0,0, 1));
        vecs.push_back(mkVec(0,0,0,0,  1,0,20,0,  0,1, 0,0, 0,0, 1,0,20,0, 1));
        vecs.push_back(mkVec(0,0,0,0,  1,0,21,0,  0,1, 0,0, 1,memInit(20), 1,0,21,0, 1));
        vecs.push_back(mkVec(0,0,0,0,  0,0,0,0,   0,1, 0,0, 1,memInit(21), 0,0,0,0, 1));
        vecs.push_back(mkVec(0,0,0,0,  0,0,0,0,   0,0, 0,0, 0,0, 0,0,0,0, 0));
        // Single read from port 1.
        vecs.push_back(mkVec(1,0,5,0,  0,0,0,0,   0,0, 0,0, 0,0, 0,0,0,0, 0));
        vecs.push_back(mkVec(1,0,5,0,  0,0,0,0,   1,0, 0,0, 0,0, 1,0,5,0, 1));
        vecs.push_back(mkVec(0,0,0,0,  0,0,0,0,   1,0, 1,memInit(5), 0,0, 0,0,0,0, 1));
        vecs.push_back(mkVec(0,0,0,0,  0,0,0,0,   0,0, 0,0, 0,0, 0,0,0,0, 0));
        // Port 2 writes 0xA5 to 100, then reads it back.
        vecs.push_back(mkVec(0,0,0,0,  1,1,100,'hA5, 0,0, 0,0, 0,0, 0,0,0,0, 0));
        vecs.push_back(mkVec(0,0,0,0,  1,1,100,'hA5, 0,1, 0,0, 0,0, 1,1,100,'hA5, 1));
        vecs.push_back(mkVec(0,0,0,0,  1,0,100,0, 0,1, 0,0, 0,0, 1,0,100,0, 1));
        vecs.push_back(mkVec(0,0,0,0,  0,0,0,0,   0,1, 0,0, 1,'hA5, 0,0,0,0, 1));
        vecs.push_back(mkVec(0,0,0,0,  0,0,0,0,   0,0, 0,0, 0,0, 0,0,0,0, 0));
        // Both held: 4 accesses each, alternating.
        vecs.push_back(mkVec(1,0,1,0,  1,0,2,0,   0,0, 0,0, 0,0, 0,0,0,0, 0));
        vecs.push_back(mkVec(1,0,1,0,  1,0,2,0,   1,0, 0,0, 0,0, 1,0,1,0, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mkVec(1,0,1,0, 1,0,2,0, 1,0, 1,memInit(1), 0,0, 1,0,1,0, 1));
        vecs.push_back(mkVec(1,0,1,0,  1,0,2,0,   0,1, 1,memInit(1), 0,0, 1,0,2,0, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mkVec(1,0,1,0, 1,0,2,0, 0,1, 0,0, 1,memInit(2), 1,0,2,0, 1));
        vecs.push_back(mkVec(1,0,1,0,  1,0,2,0,   1,0, 0,0, 1,memInit(2), 1,0,1,0, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mkVec(1,0,1,0, 1,0,2,0, 1,0, 1,memInit(1), 0,0, 1,0,1,0, 1));
        vecs.push_back(mkVec(1,0,1,0,  1,0,2,0,   0,1, 1,memInit(1), 0,0, 1,0,2,0, 1));
        vecs.push_back(mkVec(0,0,0,0,  0,0,0,0,   0,1, 0,0, 1,memInit(2), 0,0,0,0, 1));
        vecs.push_back(mkVec(0,0,0,0,  0,0,0,0,   0,0, 0,0, 0,0, 0,0,0,0, 0));
        // Port 2 rises on the very cycle port 1 reaches the limit.
        vecs.push_back(mkVec(1,0,3,0,  0,0,0,0,   0,0, 0,0, 0,0, 0,0,0,0, 0));
        vecs.push_back(mkVec(1,0,3,0,  0,0,0,0,   1,0, 0,0, 0,0, 1,0,3,0, 1));
        vecs.push_back(mkVec(1,0,3,0,  0,0,0,0,   1,0, 1,memInit(3), 0,0, 1,0,3,0, 1));
        vecs.push_back(mkVec(1,0,3,0,  0,0,0,0,   1,0, 1,memInit(3), 0,0, 1,0,3,0, 1));
        vecs.push_back(mkVec(1,0,3,0,  1,0,4,0,   1,0, 1,memInit(3), 0,0, 1,0,3,0, 1));
        vecs.push_back(mkVec(1,0,3,0,  1,0,4,0,   0,1, 1,memInit(3), 0,0, 1,0,4,0, 1));
        vecs.push_back(mkVec(1,0,3,0,  0,0,0,0,   0,1, 0,0, 1,memInit(4), 0,0,0,0, 1));
        vecs.push_back(mkVec(1,0,3,0,  0,0,0,0,   1,0, 0,0, 0,0, 1,0,3,0, 1));
        vecs.push_back(mkVec(0,0,0,0,  0,0,0,0,   1,0, 1,memInit(3), 0,0, 0,0,0,0, 1));
        vecs.push_back(mkVec(0,0,0,0,  0,0,0,0,   0,0, 0,0, 0,0, 0,0,0,0, 0));
    endtask

    initial begin
        vectorsApplied = 0;
        miscompares    = 0;
        rst = 1'b1;
        driveIdle();
        buildTable();

        // Reset state.
        #3;
        checkOutput("reset gnt1",    32'(bus.gnt1),    32'd0);
        checkOutput("reset gnt2",    32'(bus.gnt2),    32'd0);
        checkOutput("reset rvalid1", 32'(bus.rvalid1), 32'd0);
        checkOutput("reset rvalid2", 32'(bus.rvalid2), 32'd0);
        checkOutput("reset ram_CE",  32'(bus.ram_CE),  32'd0);
        checkOutput("reset busy",    32'(bus.busy),    32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #2;
            checkVector(i, vecs[i]);
        end

        // Port 1 streams alone for 40 cycles: grant never drops.
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = AW'(k);
            #2;
            checkOutput($sformatf("solo%0d gnt1", k), 32'(bus.gnt1), (k >= 1) ? 32'd1 : 32'd0);
            checkOutput($sformatf("solo%0d gnt2", k), 32'(bus.gnt2), 32'd0);
            if (k >= 2) begin
                checkOutput($sformatf("solo%0d rvalid1", k), 32'(bus.rvalid1), 32'd1);
                checkOutput($sformatf("solo%0d rdata1", k),  32'(bus.rdata1),  32'(memInit(k - 1)));
            end
        end
        @(negedge clk);
        driveIdle();
        #2;
        checkOutput("solo end rdata1", 32'(bus.rdata1), 32'(memInit(39)));
        @(negedge clk);
        #2;
        checkOutput("solo end busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of a port 2 read stream.
        @(negedge clk);
        bus.req2 = 1'b1; bus.we2 = 1'b0; bus.addr2 = AW'(7);
        @(negedge clk);
        #2;
        checkOutput("rst seq gnt2", 32'(bus.gnt2), 32'd1);
        @(negedge clk);
        #2;
        checkOutput("rst seq rvalid2 before", 32'(bus.rvalid2), 32'd1);
        checkOutput("rst seq rdata2 before",  32'(bus.rdata2),  32'(memInit(7)));
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst seq gnt2 after",    32'(bus.gnt2),    32'd0);
        checkOutput("rst seq rvalid2 after", 32'(bus.rvalid2), 32'd0);
        checkOutput("rst seq rdata2 after",  32'(bus.rdata2),  32'd0);
        checkOutput("rst seq ram_CE after",  32'(bus.ram_CE),  32'd0);
        checkOutput("rst seq busy after",    32'(bus.busy),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = AW'(9);
        @(negedge clk);
        #2;
        checkOutput("post rst tie gnt1", 32'(bus.gnt1),        32'd1);
        checkOutput("post rst tie gnt2", 32'(bus.gnt2),        32'd0);
        checkOutput("post rst tie addr", 32'(bus.ram_address), 32'd9);
        @(negedge clk);
        driveIdle();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
